// File: rtl/lth_8bit_core.sv
// Registered signed 8-bit less-than compare (r = x < y), optional eq/gt flags (macro LTH_8BIT_FLAGS_EN).
// Latency 1 cycle from an in_valid edge; one compare accepted every cycle.
// No backpressure: in_valid is a pure strobe. Idle cycles drop out_valid and hold r/eq/gt.
module lth_8bit_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       in_valid,
    output logic       r,
    output logic       out_valid
`ifdef LTH_8BIT_FLAGS_EN
    ,
    output logic       eq,
    output logic       gt
`endif
);

    // Operands sign-extended to 9 bits so the difference can never wrap.
    logic [8:0] a_ext;
    logic [8:0] b_inv;
    logic [8:0] carry;
    logic [8:0] diff;

    // Compare terms derived from the low byte of the difference.
    logic       n_flag;
    logic       v_flag;
    logic       lt;
    logic       eq_c;
    logic       gt_c;

    // Output registers and their next-state values.
    logic       r_q,   r_d;
    logic       out_valid_q;
`ifdef LTH_8BIT_FLAGS_EN
    logic       eq_q,  eq_d;
    logic       gt_q,  gt_d;
`endif

    assign a_ext = {x[7], x};
    assign b_inv = ~{y[7], y};

    // Ripple subtractor: diff = x + ~y + 1, borrow carried bit by bit.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            diff[i]      = a_ext[i] ^ b_inv[i] ^ carry[i];
            carry[i + 1] = (a_ext[i] & b_inv[i]) |
                           (a_ext[i] & carry[i]) |
                           (b_inv[i] & carry[i]);
        end
        diff[8] = a_ext[8] ^ b_inv[8] ^ carry[8];
    end

    // Signed ordering from the 8-bit result: N xor V recovers the true sign
    // even when the 8-bit difference overflows (e.g. -128 - 127).
    always_comb begin
        n_flag = diff[7];
        v_flag = (x[7] != y[7]) && (diff[7] != x[7]);
        lt     = n_flag ^ v_flag;
        eq_c   = (diff[7:0] == 8'd0);
        gt_c   = !lt && !eq_c;
    end

    // The 9-bit sign never overflows, so it must always agree with N xor V.
    always_comb begin
        if (in_valid && rst_n) begin
            assert (lt == diff[8]);
        end
    end

    // Load a fresh compare on a valid strobe, otherwise hold the last result.
    always_comb begin
        r_d = in_valid ? lt : r_q;
`ifdef LTH_8BIT_FLAGS_EN
        eq_d = in_valid ? eq_c : eq_q;
        gt_d = in_valid ? gt_c : gt_q;
`endif
    end

`ifndef LTH_8BIT_FLAGS_EN
    // Flag terms only feed registers in the flags build.
    logic unused_flags;
    assign unused_flags = eq_c ^ gt_c;
`endif

    // Output registers; async reset clears everything and discards any pair in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef LTH_8BIT_FLAGS_EN
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
`endif
        end else begin
            r_q         <= r_d;
            out_valid_q <= in_valid;
`ifdef LTH_8BIT_FLAGS_EN
            eq_q        <= eq_d;
            gt_q        <= gt_d;
`endif
        end
    end

    assign r         = r_q;
    assign out_valid = out_valid_q;
`ifdef LTH_8BIT_FLAGS_EN
    assign eq        = eq_q;
    assign gt        = gt_q;
`endif

endmodule

// File: tb/tb_lth_8bit_core.sv
// Scoreboard bench for lth_8bit_core: driver pushes expected outputs per edge, monitor pops at negedge.
// Reference is plain signed integer comparison with a held-value model for idle cycles.
// Directed corners, reset mid-stream, random mix, then an exhaustive sweep of all pairs.
module tb_lth_8bit_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;
    logic       in_valid;
    logic       r;
    logic       out_valid;
`ifdef LTH_8BIT_FLAGS_EN
    logic       eq;
    logic       gt;
`endif

    lth_8bit_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .r         (r),
        .out_valid (out_valid)
`ifdef LTH_8BIT_FLAGS_EN
        ,
        .eq        (eq),
        .gt        (gt)
`endif
    );

    typedef struct packed {
        logic vld;
        logic r;
        logic eq;
        logic gt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the held output values.
    logic m_r  = 1'b0;
    logic m_eq = 1'b0;
    logic m_gt = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    endtask

    // One edge of stimulus: compute expectation from signed arithmetic, push it once the edge consumed the inputs.
    task automatic step(input logic vld, input logic [7:0] xv, input logic [7:0] yv);
        exp_t e;
        int   xi;
        int   yi;
        x        = xv;
        y        = yv;
        in_valid = vld;
        xi = $signed(xv);
        yi = $signed(yv);
        if (!rst_n) begin
            m_r = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
            e.vld = 1'b0;
        end else if (vld) begin
            m_r  = (xi < yi);
            m_eq = (xi == yi);
            m_gt = (xi > yi);
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.r  = m_r;
        e.eq = m_eq;
        e.gt = m_gt;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every negedge with a pending expectation, compare the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", out_valid, e.vld);
                chk("r", r, e.r);
`ifdef LTH_8BIT_FLAGS_EN
                chk("eq", eq, e.eq);
                chk("gt", gt, e.gt);
                if (out_valid) chk("one_hot", (32'(r) + 32'(eq) + 32'(gt)) == 1, 1'b1);
`endif
            end else if (out_valid) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("scoreboard_drained", exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        x        = 8'd0;
        y        = 8'd0;
        in_valid = 1'b0;
        #2;
        chk("reset_r", r, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
`ifdef LTH_8BIT_FLAGS_EN
        chk("reset_eq", eq, 1'b0);
        chk("reset_gt", gt, 1'b0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic, overflow corners, equality then idle hold.
        step(1'b1, 8'd5, 8'd7);
        step(1'b1, 8'd5, 8'hF9);
        step(1'b1, 8'hF9, 8'd5);
        step(1'b1, 8'h80, 8'h7F);
        step(1'b1, 8'h7F, 8'h80);
        step(1'b1, 8'h80, 8'h80);
        step(1'b1, 8'hFD, 8'hFD);
        step(1'b0, 8'd0, 8'd1);
        step(1'b0, 8'd0, 8'd1);
        // Back-to-back opposite results.
        step(1'b1, 8'd1, 8'd2);
        step(1'b1, 8'd2, 8'd1);
        // Establish r=1 then reset between edges.
        step(1'b1, 8'd1, 8'd2);
        drain();
        #2 rst_n = 1'b0;
        m_r = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
        #1;
        chk("async_reset_r", r, 1'b0);
        chk("async_reset_out_valid", out_valid, 1'b0);
        step(1'b1, 8'h80, 8'h7F);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 8'hFF, 8'd0);
        step(1'b0, 8'd9, 8'd3);

        // Random mix of valid and idle cycles.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        end

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] p;
            p = 16'(i);
            step(1'b1, p[15:8], p[7:0]);
        end
        step(1'b0, 8'd0, 8'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
